// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and nibble constants for the BCD conversion sequencer
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_NIBBLE = 4;
  localparam logic [BCD_NIBBLE-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_convert_sequencer_if.sv
// rtl/bcd_convert_sequencer_if.sv - input/output handshakes and digit bus of the BCD conversion sequencer
interface bcd_convert_sequencer_if #(
  parameter int WIDTH = 8
);
  import bcd_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BCD_NIBBLE-1:0] ones;
  logic [BCD_NIBBLE-1:0] tens;
  logic [BCD_NIBBLE-1:0] hundreds;
  logic                  sign;
  logic                  busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, ones, tens, hundreds, sign, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, ones, tens, hundreds, sign, busy
  );

endinterface

// File: rtl/bcd_add3_adjust.sv
// rtl/bcd_add3_adjust.sv - double-dabble nibble corrector: adds 3 to any BCD digit of 5 or more
module bcd_add3_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] nib_i,
  output logic [BCD_NIBBLE-1:0] nib_o
);

  assign nib_o = (nib_i >= ADD3_THRESH) ? nib_i + BCD_NIBBLE'(3) : nib_i;

endmodule

// File: rtl/bcd_convert_sequencer.sv
// rtl/bcd_convert_sequencer.sv - one-step-per-clock binary-to-BCD converter (double-dabble)
// Optional macro BCD_SIGNED_EN: treat bin_in as two's complement and report sign.
module bcd_convert_sequencer
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic               clk,
  input logic               rst,
  bcd_convert_sequencer_if.slave bus
);

  localparam int SR_W  = DIGITS * BCD_NIBBLE + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e                state_q, state_d;
  logic [SR_W-1:0]       sr_q, sr_d, sr_adj, sr_shl;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BCD_NIBBLE-1:0] ones_q, ones_d;
  logic [BCD_NIBBLE-1:0] tens_q, tens_d;
  logic [BCD_NIBBLE-1:0] hund_q, hund_d;
  logic [WIDTH-1:0]      load_val;

  // Binary field passes through; each BCD digit is corrected before the shift.
  assign sr_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3_adjust u_adj (
      .nib_i (sr_q  [WIDTH + g*BCD_NIBBLE +: BCD_NIBBLE]),
      .nib_o (sr_adj[WIDTH + g*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end
  assign sr_shl = sr_adj << 1;

`ifdef BCD_SIGNED_EN
  logic neg_q, neg_d;
  logic sign_q, sign_d;
  // Negating the most negative code wraps to the same bits, read as unsigned 2^(WIDTH-1).
  assign load_val = bus.bin_in[WIDTH-1] ? (~bus.bin_in + WIDTH'(1)) : bus.bin_in;
  assign bus.sign = sign_q;
`else
  assign load_val = bus.bin_in;
  assign bus.sign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
`ifdef BCD_SIGNED_EN
    neg_d   = neg_q;
    sign_d  = sign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sr_d    = {{(DIGITS*BCD_NIBBLE){1'b0}}, load_val};
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef BCD_SIGNED_EN
          neg_d   = bus.bin_in[WIDTH-1];
`endif
        end
      end
      ST_SHIFT: begin
        sr_d  = sr_shl;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          ones_d  = sr_shl[WIDTH                +: BCD_NIBBLE];
          tens_d  = sr_shl[WIDTH + BCD_NIBBLE   +: BCD_NIBBLE];
          hund_d  = sr_shl[WIDTH + 2*BCD_NIBBLE +: BCD_NIBBLE];
`ifdef BCD_SIGNED_EN
          sign_d  = neg_q;
`endif
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
`ifdef BCD_SIGNED_EN
      neg_q   <= 1'b0;
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
`ifdef BCD_SIGNED_EN
      neg_q   <= neg_d;
      sign_q  <= sign_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.ones      = ones_q;
  assign bus.tens      = tens_q;
  assign bus.hundreds  = hund_q;

endmodule
